// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two write ports, write-first bypass and a
// per-register busy scoreboard for RAW hazard detection.
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Wr_En_A,
  input  logic [ADDR_W-1:0]          Wr_Addr_A,
  input  logic [DATA_W-1:0]          Wr_Data_A,
  input  logic                       Wr_En_B,
  input  logic [ADDR_W-1:0]          Wr_Addr_B,
  input  logic [DATA_W-1:0]          Wr_Data_B,
  input  logic [NUM_RD*ADDR_W-1:0]   Rd_Addr,
  output logic [NUM_RD*DATA_W-1:0]   Rd_Data,
  output logic [NUM_RD-1:0]          Rd_Busy,
  input  logic                       Busy_Set,
  input  logic [ADDR_W-1:0]          Busy_Set_Addr,
  input  logic [ADDR_W-1:0]          Dbg_Addr,
  output logic [DATA_W-1:0]          Dbg_Data,
  output logic                       Busy_Any
);

  localparam int DEPTH = 2**ADDR_W;

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regfile_mp_sb: NUM_RD must be in 1..4");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic              wr_ok_a;
  logic              wr_ok_b;
  logic              set_ok;

  // Register 0 is hard-wired when ZERO_REG is set: writes and busy marks are dropped.
  assign wr_ok_a = Wr_En_A  && !(ZERO_REG != 0 && Wr_Addr_A     == '0);
  assign wr_ok_b = Wr_En_B  && !(ZERO_REG != 0 && Wr_Addr_B     == '0);
  assign set_ok  = Busy_Set && !(ZERO_REG != 0 && Busy_Set_Addr == '0);

  // NOTE: every variable in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    busy_next = busy;
    if (wr_ok_a) busy_next[Wr_Addr_A] = 1'b0;
    if (wr_ok_b) busy_next[Wr_Addr_B] = 1'b0;
    // A new producer issued alongside a writeback keeps the register busy.
    if (set_ok)  busy_next[Busy_Set_Addr] = 1'b1;
  end

  // NOTE: the storage array is reset as a whole because reset must clear architectural
  // state; the later non-blocking write to the same entry (port B) wins.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_ok_a) mem[Wr_Addr_A] <= Wr_Data_A;
      if (wr_ok_b) mem[Wr_Addr_B] <= Wr_Data_B;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) busy <= '0;
    else       busy <= busy_next;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit_a;
    logic              hit_b;
    logic [DATA_W-1:0] data;

    assign addr  = Rd_Addr[i*ADDR_W +: ADDR_W];
    assign hit_a = Wr_En_A && (Wr_Addr_A == addr);
    assign hit_b = Wr_En_B && (Wr_Addr_B == addr);

    always_comb begin
      data = mem[addr];
      if (BYPASS != 0) begin
        if (hit_b)      data = Wr_Data_B;
        else if (hit_a) data = Wr_Data_A;
      end
      if (ZERO_REG != 0 && addr == '0) data = '0;
    end

    assign Rd_Data[i*DATA_W +: DATA_W] = data;
    // A writeback landing this cycle resolves the hazard when its data is forwarded.
    assign Rd_Busy[i] = busy[addr] && !(BYPASS != 0 && (hit_a || hit_b));
  end

  assign Dbg_Data = mem[Dbg_Addr];
  assign Busy_Any = |busy;

endmodule
